cacheline_adaptor: RTL and testbench

- Sits between the L2 cache and physical memory; its memory-side ports are the top-level mem_* pins of mp3.
- Converts one full-line L2 miss fill or writeback into a burst of BURST_W-wide memory beats.
- Handles read (fill) and write (writeback) transactions; one transaction outstanding at a time.
- Exposes saturating transaction counters for the bench's performance report, alongside the cache hit/miss counts.

---
 rtl/cacheline_pkg.sv | 25 ++
 rtl/cacheline_adaptor_if.sv | 30 +++
 rtl/sat_counter.sv | 23 ++
 rtl/cacheline_adaptor.sv | 113 +++++++++++
 tb/tb_cacheline_adaptor.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cacheline_pkg.sv
// Shared types and geometry for the L2-to-memory cache line adaptor.
// Beat 0 of a line occupies bits [BURST_W-1:0].
package cacheline_pkg;

   localparam int unsigned LINE_W     = 256;
   localparam int unsigned BURST_W    = 64;
   localparam int unsigned BEATS      = LINE_W / BURST_W;
   localparam int unsigned OFFSET_W   = 5;
   localparam int unsigned BEAT_IDX_W = $clog2(BEATS);

   localparam logic [31:0]           ADDR_MASK = ~((32'd1 << OFFSET_W) - 32'd1);
   localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

   typedef logic [LINE_W-1:0]              line_t;
   typedef logic [BURST_W-1:0]             burst_t;
   typedef logic [BEATS-1:0][BURST_W-1:0]  beats_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RD_BURST = 2'd1,
      WR_BURST = 2'd2,
      DONE     = 2'd3
   } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// L2-side and memory-side signals of the cache line adaptor.
// The slave modport is the adaptor's view; master is the environment's view.
interface cacheline_adaptor_if;
   import cacheline_pkg::*;

   line_t       line_i;
   line_t       line_o;
   logic [31:0] address_i;
   logic        read_i;
   logic        write_i;
   logic        resp_o;

   burst_t      burst_i;
   burst_t      burst_o;
   logic [31:0] address_o;
   logic        read_o;
   logic        write_o;
   logic        resp_i;

   modport slave (
      input  line_i, address_i, read_i, write_i, burst_i, resp_i,
      output line_o, resp_o, burst_o, address_o, read_o, write_o
   );

   modport master (
      output line_i, address_i, read_i, write_i, burst_i, resp_i,
      input  line_o, resp_o, burst_o, address_o, read_o, write_o
   );

endinterface

// File: rtl/sat_counter.sv
// CNT_W-wide event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/cacheline_adaptor.sv
// Splits one L2 line fill or writeback into BEATS memory bursts, one transaction at a time.
// Memory-side outputs derive only from registered state.
module cacheline_adaptor
   import cacheline_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   cacheline_adaptor_if.slave  bus,
   output logic [CNT_W-1:0]    rd_count,
   output logic [CNT_W-1:0]    wr_count
);

   adaptor_state_t          r_state;
   adaptor_state_t          w_state_d;
   logic [BEAT_IDX_W-1:0]   r_cnt;
   logic [31:0]             r_addr;
   beats_t                  r_wline;
   beats_t                  r_rline;
   logic                    r_op_wr;

   logic                    w_in_burst;
   logic                    w_beat_go;
   logic                    w_beat_last;
   logic [31:0]             w_addr_aligned;
   logic                    w_rd_inc;
   logic                    w_wr_inc;

   assign w_in_burst     = (r_state == RD_BURST) || (r_state == WR_BURST);
   assign w_beat_go      = w_in_burst && bus.resp_i;
   assign w_beat_last    = w_beat_go && (r_cnt == LAST_BEAT);
   assign w_addr_aligned = bus.address_i & ADDR_MASK;

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         IDLE: begin
            // write wins if both requests arrive together
            if (bus.write_i) begin
               w_state_d = WR_BURST;
            end else if (bus.read_i) begin
               w_state_d = RD_BURST;
            end
         end
         RD_BURST, WR_BURST: begin
            if (w_beat_last) begin
               w_state_d = DONE;
            end
         end
         DONE:    w_state_d = IDLE;
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wline <= '0;
         r_rline <= '0;
         r_op_wr <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (r_state == IDLE) begin
            if (bus.write_i) begin
               r_addr  <= w_addr_aligned;
               r_wline <= bus.line_i;
               r_op_wr <= 1'b1;
            end else if (bus.read_i) begin
               r_addr  <= w_addr_aligned;
               r_op_wr <= 1'b0;
            end
         end
         if (w_beat_go) begin
            r_cnt <= w_beat_last ? '0 : r_cnt + 1'b1;
            if (r_state == RD_BURST) begin
               r_rline[r_cnt] <= bus.burst_i;
            end
         end
      end
   end

   assign bus.read_o    = (r_state == RD_BURST);
   assign bus.write_o   = (r_state == WR_BURST);
   assign bus.resp_o    = (r_state == DONE);
   assign bus.address_o = r_addr;
   assign bus.burst_o   = (r_state == WR_BURST) ? r_wline[r_cnt] : '0;
   assign bus.line_o    = r_rline;

   assign w_rd_inc = (r_state == DONE) && !r_op_wr;
   assign w_wr_inc = (r_state == DONE) &&  r_op_wr;

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_rd_count (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_rd_inc),
      .o_count (rd_count)
   );

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_wr_count (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_wr_inc),
      .o_count (wr_count)
   );

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench: a behavioural memory answers bursts, a line-level model predicts results.
module tb_cacheline_adaptor;
   import cacheline_pkg::*;

   localparam int unsigned CNT_W   = 4;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [CNT_W-1:0] rd_count;
   logic [CNT_W-1:0] wr_count;

   cacheline_adaptor_if bus ();

   cacheline_adaptor #(
      .CNT_W (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .rd_count (rd_count),
      .wr_count (wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      line_t       line;
   } txn_t;

   txn_t  exp_q[$];
   line_t phys    [logic [31:0]];
   line_t ref_mem [logic [31:0]];
   int    n_vec = 0;
   int    n_err = 0;
   int    exp_rd = 0;
   int    exp_wr = 0;
   bit    b2b = 1'b0;
   bit    stray_en = 1'b0;

   function automatic void check(input string name, input logic [LINE_W-1:0] act,
                                 input logic [LINE_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic line_t seed_line(input logic [31:0] a);
      line_t l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = (a * 32'h9E37_79B9) + 32'(i);
      return l;
   endfunction

   function automatic line_t rand_line();
      line_t l;
      for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   // Memory responder: random wait states, stray resp_i pulses while idle.
   initial begin
      int    rcnt;
      line_t wbuf;
      line_t rl;
      rcnt = 0;
      wbuf = '0;
      bus.resp_i  = 1'b0;
      bus.burst_i = '0;
      forever begin
         @(negedge clk);
         if (bus.read_o || bus.write_o) begin
            if (b2b || ($urandom_range(0, 2) != 0)) begin
               bus.resp_i = 1'b1;
               if (bus.read_o) begin
                  if (!phys.exists(bus.address_o)) phys[bus.address_o] = seed_line(bus.address_o);
                  rl = phys[bus.address_o];
                  bus.burst_i = rl[rcnt*BURST_W +: BURST_W];
               end else begin
                  wbuf[rcnt*BURST_W +: BURST_W] = bus.burst_o;
                  if (rcnt == BEATS - 1) phys[bus.address_o] = wbuf;
                  bus.burst_i = {$urandom, $urandom};
               end
               rcnt++;
            end else begin
               bus.resp_i  = 1'b0;
               bus.burst_i = {$urandom, $urandom};
            end
         end else begin
            rcnt = 0;
            bus.resp_i  = stray_en && ($urandom_range(0, 3) == 0);
            bus.burst_i = {$urandom, $urandom};
         end
      end
   end

   // Monitor: checks in-flight memory requests and each completion against the scoreboard.
   initial begin
      txn_t  t;
      line_t got;
      forever begin
         @(negedge clk);
         if (rst && (bus.read_o || bus.write_o) && (exp_q.size() > 0)) begin
            check("mem_addr", bus.address_o, exp_q[0].addr);
            check("mem_mode", {bus.read_o, bus.write_o}, exp_q[0].wr ? 2'b01 : 2'b10);
         end
         if (bus.resp_o) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 1'b1, 1'b0);
            end else begin
               t = exp_q.pop_front();
               if (t.wr) begin
                  got = phys.exists(t.addr) ? phys[t.addr] : '0;
                  check("wr_line", got, t.line);
               end else begin
                  check("rd_line", bus.line_o, t.line);
               end
               check("rd_count_pre", rd_count, exp_rd);
               check("wr_count_pre", wr_count, exp_wr);
               if (t.wr) exp_wr = (exp_wr < CNT_MAX) ? exp_wr + 1 : CNT_MAX;
               else      exp_rd = (exp_rd < CNT_MAX) ? exp_rd + 1 : CNT_MAX;
            end
         end
      end
   end

   // op: 0 read, 1 write, 2 both (write expected). lat = cycles from acceptance to resp_o.
   task automatic do_txn(input int op, input logic [31:0] a, input line_t l, output int lat);
      txn_t t;
      int   w;
      @(negedge clk);
      bus.address_i = a;
      bus.line_i    = l;
      bus.read_i    = (op != 1);
      bus.write_i   = (op != 0);
      t.wr   = (op != 0);
      t.addr = a & ADDR_MASK;
      if (t.wr) begin
         t.line = l;
         ref_mem[t.addr] = l;
      end else begin
         if (!ref_mem.exists(t.addr)) ref_mem[t.addr] = seed_line(t.addr);
         t.line = ref_mem[t.addr];
      end
      exp_q.push_back(t);
      @(negedge clk);
      bus.line_i    = rand_line();
      bus.address_i = $urandom;
      w = 0;
      while (!bus.resp_o && (w < 200)) begin
         @(negedge clk);
         w++;
      end
      if (!bus.resp_o) begin
         check("resp_timeout", 1'b0, 1'b1);
         lat = -1;
      end else begin
         lat = w + 1;
      end
      bus.read_i  = 1'b0;
      bus.write_i = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int    lat;
      line_t l1;
      bus.line_i    = '0;
      bus.address_i = '0;
      bus.read_i    = 1'b0;
      bus.write_i   = 1'b0;
      #2;
      check("rst_read_o",  bus.read_o,    1'b0);
      check("rst_write_o", bus.write_o,   1'b0);
      check("rst_resp_o",  bus.resp_o,    1'b0);
      check("rst_burst_o", bus.burst_o,   '0);
      check("rst_addr_o",  bus.address_o, '0);
      check("rst_line_o",  bus.line_o,    '0);
      check("rst_rd_cnt",  rd_count,      '0);
      check("rst_wr_cnt",  wr_count,      '0);
      @(negedge clk);
      rst = 1'b1;

      // Directed read with back-to-back memory responses.
      b2b = 1'b1;
      l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
            64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
      phys[32'h0000_1220]    = l1;
      ref_mem[32'h0000_1220] = l1;
      do_txn(0, 32'h0000_1234, '0, lat);
      check("latency_b2b", lat, BEATS + 1);

      // Directed write with wait states, then both requests at once.
      b2b = 1'b0;
      do_txn(1, 32'h0000_2000, {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, lat);
      do_txn(2, 32'h0000_3010, rand_line(), lat);

      // Reset after two read beats, between clock edges.
      b2b = 1'b1;
      @(negedge clk);
      bus.address_i = 32'h0000_1234;
      bus.read_i    = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2;
      bus.read_i = 1'b0;
      rst = 1'b0;
      #1;
      check("mid_rst_read_o", bus.read_o, 1'b0);
      check("mid_rst_resp_o", bus.resp_o, 1'b0);
      check("mid_rst_line_o", bus.line_o, '0);
      check("mid_rst_rd_cnt", rd_count,   '0);
      exp_q.delete();
      exp_rd = 0;
      exp_wr = 0;
      @(negedge clk);
      rst = 1'b1;
      do_txn(0, 32'h0000_1234, '0, lat);
      check("latency_after_rst", lat, BEATS + 1);

      // Random traffic over a small address pool; counters saturate at CNT_MAX.
      stray_en = 1'b1;
      for (int k = 0; k < 60; k++) begin
         int          r;
         int          op;
         logic [31:0] a;
         r  = $urandom_range(0, 9);
         op = (r < 5) ? 0 : ((r < 9) ? 1 : 2);
         a  = 32'h0000_8000 + ($urandom_range(0, 7) << 5) + $urandom_range(0, 31);
         b2b = ($urandom_range(0, 2) == 0);
         do_txn(op, a, rand_line(), lat);
         if (b2b) check("latency_rand", lat, BEATS + 1);
      end

      stray_en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("final_rd_count", rd_count, exp_rd);
      check("final_wr_count", wr_count, exp_wr);
      check("final_queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
